// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, LSB-first frames with optional parity.
// Ports: clk, rst (async high), rx in; data, data_valid, parity_err, frame_err, busy out.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rx #(
  parameter int BITS         = 8,
  parameter int STOPBITS     = 1,
  parameter int PARITY       = 2,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic [BITS-1:0] data,
  output logic            data_valid,
  output logic            parity_err,
  output logic            frame_err,
  output logic            busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMP = MID + 1;
`else
  localparam int SAMP = MID;
`endif
  localparam logic [CW-1:0] SAMP_C  = CW'(SAMP);
  localparam logic [CW-1:0] LAST_C  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DLAST   = 4'(BITS - 1);
  localparam logic [3:0]    SLAST   = 4'(STOPBITS - 1);
  localparam logic          HAS_PAR = (PARITY != 0);
  localparam logic          ODD     = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t          state, state_n;
  logic            rx_m, rx_s;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      idx, idx_n;
  logic [BITS-1:0] sh, sh_n;
  logic            par, par_n;
  logic            ferr, ferr_n;
  logic [BITS-1:0] data_n;
  logic            valid_n, perr_n, ferr_o_n;
  logic            samp, bit_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist holds rx_s from the two cycles before the decision cycle
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) |
                   (hist[1] & rx_s) |
                   (hist[0] & rx_s);

  if (CLKS_PER_BIT < 4) begin : g_cpb_chk
    $error("uart_rx: CLKS_PER_BIT must be >= 4");
  end
`else
  assign bit_val = rx_s;
`endif

  assign samp = (cnt == SAMP_C);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      par        <= 1'b0;
      ferr       <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh         <= sh_n;
      par        <= par_n;
      ferr       <= ferr_n;
      data       <= data_n;
      data_valid <= valid_n;
      parity_err <= perr_n;
      frame_err  <= ferr_o_n;
    end
  end

  // The counter free-runs through the frame, so every later sample
  // lands a whole bit period after the start-bit midpoint.
  always_comb begin
    state_n  = state;
    cnt_n    = (cnt == LAST_C) ? '0 : cnt + CW'(1);
    idx_n    = idx;
    sh_n     = sh;
    par_n    = par;
    ferr_n   = ferr;
    data_n   = data;
    valid_n  = 1'b0;
    perr_n   = parity_err;
    ferr_o_n = frame_err;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
          idx_n   = '0;
          par_n   = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      START: begin
        if (samp) state_n = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (samp) begin
          sh_n = {bit_val, sh[BITS-1:1]};
          if (idx == DLAST) begin
            idx_n   = '0;
            state_n = HAS_PAR ? PAR : STOP;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      PAR: begin
        if (samp) begin
          par_n   = bit_val;
          state_n = STOP;
        end
      end
      STOP: begin
        if (samp) begin
          if (idx == SLAST) begin
            state_n  = IDLE;
            valid_n  = 1'b1;
            data_n   = sh;
            ferr_o_n = ferr | ~bit_val;
            perr_n   = HAS_PAR & ((^sh ^ par) != ODD);
          end else begin
            idx_n  = idx + 4'd1;
            ferr_n = ferr | ~bit_val;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// Table vectors, corner sequences and random frames against a frame model.
module tb_uart_rx;

  localparam int BITS = 8;
  localparam int SB   = 1;
  localparam int PAR  = 2;
  localparam int CPB  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx;
  logic [BITS-1:0] data;
  logic            data_valid, parity_err, frame_err, busy;

  uart_rx #(
    .BITS(BITS), .STOPBITS(SB), .PARITY(PAR), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // strobe log: {busy, frame_err, parity_err, data}
  logic [10:0] got_q[$];
  int          busy_cnt = 0;

  always @(negedge clk) begin
    if (data_valid)
      got_q.push_back({busy, frame_err, parity_err, data});
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // line-level transmitter model
  logic fq[$];

  function automatic void build(input logic [7:0] d, input bit flip,
                                input logic stopv);
    logic p;
    fq.delete();
    fq.push_back(1'b0);
    for (int i = 0; i < BITS; i++) fq.push_back(d[i]);
    p = (^d) ^ (PAR == 1);
    if (PAR != 0) fq.push_back(p ^ flip);
    for (int i = 0; i < SB; i++) fq.push_back(stopv);
  endfunction

  // frame-level receiver model: decodes the bit list
  function automatic logic [9:0] decode();
    logic [7:0] d;
    logic pe, fe;
    int   pos;
    d = '0;
    for (int i = 0; i < BITS; i++) d[i] = fq[1 + i];
    pos = 1 + BITS;
    pe = 1'b0;
    if (PAR != 0) begin
      pe  = ((^d) ^ fq[pos]) != (PAR == 1);
      pos = pos + 1;
    end
    fe = 1'b0;
    for (int i = 0; i < SB; i++) if (!fq[pos + i]) fe = 1'b1;
    return {fe, pe, d};
  endfunction

  task automatic line(input logic v, input bit glitch);
    for (int k = 0; k < CPB; k++) begin
      rx = (glitch && k == 9) ? 1'b0 : v;
      @(negedge clk);
    end
  endtask

  task automatic send_q(input int gbit);
    for (int i = 0; i < fq.size(); i++)
      line(fq[i], gbit >= 0 && i == gbit + 1);
  endtask

  task automatic idle(input int nbits);
    for (int i = 0; i < nbits; i++) line(1'b1, 1'b0);
  endtask

  task automatic chk_entry(input string name, input int i,
                           input logic [7:0] ed, input logic ep,
                           input logic ef);
    logic [10:0] e;
    e = (i < got_q.size()) ? got_q[i] : 11'h7ff;
    chk({name, ".data"}, 32'(e[7:0]), 32'(ed));
    chk({name, ".perr"}, 32'(e[8]), 32'(ep));
    chk({name, ".ferr"}, 32'(e[9]), 32'(ef));
    chk({name, ".busy_at_strobe"}, 32'(e[10]), 32'd0);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         flip;
    logic       stopv;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int base, b0;
    logic [9:0] m;
    logic [7:0] rd;
    bit rf;
    logic rs;

    tbl[0] = '{8'h57, 1'b0, 1'b1, 8'h57, 1'b0, 1'b0};
    tbl[1] = '{8'h57, 1'b1, 1'b1, 8'h57, 1'b1, 1'b0};
    tbl[2] = '{8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
    tbl[3] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.data", 32'(data), 32'd0);
    chk("rst.valid", 32'(data_valid), 32'd0);
    chk("rst.perr", 32'(parity_err), 32'd0);
    chk("rst.ferr", 32'(frame_err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(2);

    for (int t = 0; t < 4; t++) begin
      base = got_q.size();
      build(tbl[t].d, tbl[t].flip, tbl[t].stopv);
      send_q(-1);
      idle(2);
      chk($sformatf("tbl%0d.count", t), 32'(got_q.size()), 32'(base + 1));
      chk_entry($sformatf("tbl%0d", t), base,
                tbl[t].ed, tbl[t].ep, tbl[t].ef);
      chk($sformatf("tbl%0d.busy_after", t), 32'(busy), 32'd0);
    end

    // runt start: rejected, nothing changes
    base = got_q.size();
    b0   = busy_cnt;
    rx   = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    idle(3);
    chk("runt.count", 32'(got_q.size()), 32'(base));
    chk("runt.busy_pulsed", 32'(busy_cnt > b0), 32'd1);
    chk("runt.busy_after", 32'(busy), 32'd0);
    chk("runt.data_kept", 32'(data), 32'hA5);
    chk("runt.ferr_kept", 32'(frame_err), 32'd0);

    // back-to-back frames with no idle gap
    base = got_q.size();
    build(8'h00, 1'b0, 1'b1); send_q(-1);
    build(8'hFF, 1'b0, 1'b1); send_q(-1);
    build(8'h3C, 1'b0, 1'b1); send_q(-1);
    idle(2);
    chk("b2b.count", 32'(got_q.size()), 32'(base + 3));
    chk_entry("b2b0", base,     8'h00, 1'b0, 1'b0);
    chk_entry("b2b1", base + 1, 8'hFF, 1'b0, 1'b0);
    chk_entry("b2b2", base + 2, 8'h3C, 1'b0, 1'b0);

    // reset in the middle of the data bits
    base = got_q.size();
    build(8'h81, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) line(fq[i], 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst.data", 32'(data), 32'd0);
    chk("midrst.valid", 32'(data_valid), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.perr", 32'(parity_err), 32'd0);
    chk("midrst.ferr", 32'(frame_err), 32'd0);
    @(negedge clk);
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    chk("midrst.count", 32'(got_q.size()), 32'(base));
    build(8'h42, 1'b0, 1'b1);
    send_q(-1);
    idle(2);
    chk("post_rst.count", 32'(got_q.size()), 32'(base + 1));
    chk_entry("post_rst", base, 8'h42, 1'b0, 1'b0);

`ifdef UART_RX_MAJORITY_EN
    base = got_q.size();
    build(8'h42, 1'b0, 1'b1);
    send_q(6);
    idle(2);
    chk("glitch.count", 32'(got_q.size()), 32'(base + 1));
    chk_entry("glitch", base, 8'h42, 1'b0, 1'b0);
`endif

    // random frames against the frame-level model
    for (int r = 0; r < 24; r++) begin
      rd   = 8'($urandom);
      rf   = ($urandom_range(0, 3) == 0);
      rs   = ($urandom_range(0, 4) != 0);
      base = got_q.size();
      build(rd, rf, rs);
      m = decode();
      send_q(-1);
      idle($urandom_range(1, 2));
      chk($sformatf("rnd%0d.count", r), 32'(got_q.size()), 32'(base + 1));
      chk_entry($sformatf("rnd%0d", r), base, m[7:0], m[8], m[9]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
